mem_access_unit: RTL



---
 rtl/mem_access_unit.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store adapter onto a word-organised Wishbone port
// Optional build macro: MEM_ACCESS_MISALIGNED_SPLIT_EN (split misaligned accesses into two word cycles)
module mem_access_unit #(
    parameter int MEM_ADDR_WIDTH = 30
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_cpu_stb,
    input  logic                      i_cpu_we,
    input  logic [31:0]               i_cpu_addr,
    input  logic [31:0]               i_cpu_data,
    input  logic [2:0]                i_cpu_sel,
    output logic [31:0]               o_cpu_data,
    output logic                      o_cpu_ack,
    output logic                      o_cpu_stall,
    output logic                      o_cpu_err,
    output logic                      o_mem_stb,
    output logic                      o_mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]               o_mem_data,
    output logic [3:0]                o_mem_sel,
    input  logic [31:0]               i_mem_data,
    input  logic                      i_mem_ack,
    input  logic                      i_mem_stall
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_RESP
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
        ,
        S_ISSUE1,
        S_WAIT1
`endif
    } state_t;

    state_t state, state_next;

    // Request latched at acceptance; the CPU side is ignored while busy.
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        we_q;
    logic [2:0]  sel_q;
    logic        err_q;
    logic [31:0] word0_q;

    logic req_illegal, req_misaligned, req_reject;
    logic accept, issue0, capture0, respond;

    logic [1:0]                off;
    logic [4:0]                sh;
    logic [3:0]                size_mask;
    logic [3:0]                lanes_w0;
    logic [31:0]               data_w0;
    logic [MEM_ADDR_WIDTH-1:0] idx_w0;
    logic [31:0]               shifted;
    logic [31:0]               load_ext;

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    logic                      split_q;
    logic [31:0]               word1_q;
    logic                      issue1, capture1;
    logic [3:0]                lanes_w1;
    logic [31:0]               data_w1;
    logic [MEM_ADDR_WIDTH-1:0] idx_w1;
`endif

    // Classify the incoming request: illegal size code, misaligned, or rejected outright.
    always_comb begin
        req_illegal = 1'b0;
        case (i_cpu_sel)
            3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
            3'b100, 3'b101:         req_illegal = i_cpu_we;
            default:                req_illegal = 1'b1;
        endcase
        req_misaligned = ((i_cpu_sel[1:0] == 2'b01) && (i_cpu_addr[1:0] == 2'b11)) ||
                         ((i_cpu_sel[1:0] == 2'b10) && (i_cpu_addr[1:0] != 2'b00));
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
        req_reject = req_illegal;
`else
        req_reject = req_illegal | req_misaligned;
`endif
    end

    assign off    = addr_q[1:0];
    assign sh     = {off, 3'b000};
    assign idx_w0 = MEM_ADDR_WIDTH'(addr_q[31:2]);

    // Byte-lane mask of the access size before shifting to the byte offset.
    always_comb begin
        case (sel_q[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Word 0 gets the low part of the offset-shifted lanes/data; bits shifted past lane 3 go to word 1.
    assign lanes_w0 = size_mask << off;
    assign data_w0  = data_q << sh;

`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
    assign lanes_w1 = size_mask >> (3'd4 - {1'b0, off});
    assign data_w1  = data_q >> (6'd32 - {1'b0, sh});
    assign idx_w1   = idx_w0 + MEM_ADDR_WIDTH'(1);
    assign shifted  = (word0_q >> sh) | (word1_q << (6'd32 - {1'b0, sh}));
`else
    assign shifted  = word0_q >> sh;
`endif

    // Truncate the aligned load to its size; sign-extend B/H, zero-extend BU/HU/W.
    always_comb begin
        case (sel_q[1:0])
            2'b00:   load_ext = {{24{~sel_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~sel_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state and per-cycle action strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue0     = 1'b0;
        capture0   = 1'b0;
        respond    = 1'b0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
        issue1     = 1'b0;
        capture1   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (i_cpu_stb && !o_cpu_stall) begin
                    accept     = 1'b1;
                    state_next = req_reject ? S_RESP : S_ISSUE0;
                end
            end
            S_ISSUE0: begin
                if (!i_mem_stall) begin
                    issue0     = 1'b1;
                    state_next = S_WAIT0;
                end
            end
            S_WAIT0: begin
                if (i_mem_ack) begin
                    capture0   = 1'b1;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                    state_next = split_q ? S_ISSUE1 : S_RESP;
`else
                    state_next = S_RESP;
`endif
                end
            end
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            S_ISSUE1: begin
                if (!i_mem_stall) begin
                    issue1     = 1'b1;
                    state_next = S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (i_mem_ack) begin
                    capture1   = 1'b1;
                    state_next = S_RESP;
                end
            end
`endif
            S_RESP: begin
                respond    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, memory-side drive, read capture and CPU response registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            addr_q      <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            err_q       <= 1'b0;
            word0_q     <= '0;
            o_cpu_data  <= '0;
            o_cpu_ack   <= 1'b0;
            o_cpu_stall <= 1'b0;
            o_cpu_err   <= 1'b0;
            o_mem_stb   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_data  <= '0;
            o_mem_sel   <= '0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            split_q     <= 1'b0;
            word1_q     <= '0;
`endif
        end else begin
            if (accept) begin
                addr_q      <= i_cpu_addr;
                data_q      <= i_cpu_data;
                we_q        <= i_cpu_we;
                sel_q       <= i_cpu_sel;
                err_q       <= req_reject;
                o_cpu_stall <= 1'b1;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
                split_q     <= req_misaligned;
`endif
            end

            if (issue0) begin
                o_mem_stb  <= 1'b1;
                o_mem_we   <= we_q;
                o_mem_addr <= idx_w0;
                o_mem_data <= data_w0;
                o_mem_sel  <= lanes_w0;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            end else if (issue1) begin
                o_mem_stb  <= 1'b1;
                o_mem_we   <= we_q;
                o_mem_addr <= idx_w1;
                o_mem_data <= data_w1;
                o_mem_sel  <= lanes_w1;
`endif
            end else begin
                o_mem_stb  <= 1'b0;
            end

            if (capture0) word0_q <= i_mem_data;
`ifdef MEM_ACCESS_MISALIGNED_SPLIT_EN
            if (capture1) word1_q <= i_mem_data;
`endif

            if (respond) begin
                o_cpu_ack   <= 1'b1;
                o_cpu_stall <= 1'b0;
                o_cpu_err   <= err_q;
                o_cpu_data  <= (err_q || we_q) ? 32'h0 : load_ext;
            end else begin
                o_cpu_ack   <= 1'b0;
            end
        end
    end

endmodule
